// File: rtl/mmu_addresses_pkg.sv
// Shared MMU address map, bus payload types and DMA bus ownership states.
package mmu_addresses_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] HRAM_start = 16'hFF80;
    localparam logic [ADDR_W-1:0] HRAM_end   = 16'hFFFE;
    localparam logic [DATA_W-1:0] OPEN_BUS   = 8'hFF;

    typedef enum logic [1:0] {
        OWN_CPU     = 2'd0,
        OWN_DMA     = 2'd1,
        OWN_RELEASE = 2'd2
    } dma_owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              read_en;
        logic              write_en;
    } mem_req_t;

    function automatic logic in_hram(input logic [ADDR_W-1:0] addr);
        return (addr >= HRAM_start) && (addr <= HRAM_end);
    endfunction

endpackage

// File: rtl/hram_ram.sv
// High RAM storage: DEPTH x 8, combinational read, write on the clock edge.
module hram_ram #(
    parameter int unsigned DEPTH = 127,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata_c
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/dma_bus_arbiter.sv
// Hands the memory bus to the OAM DMA engine and confines the CPU to HRAM meanwhile.
// Build option: DMA_BUS_CONFLICT_EN makes blocked CPU reads return the last DMA read byte.
module dma_bus_arbiter
    import mmu_addresses_pkg::*;
#(
    parameter int unsigned HRAM_DEPTH = 127,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_read_en,
    input  logic              cpu_write_en,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_active,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_read_en,
    input  logic              dma_write_en,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_en,
    output logic              mem_write_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic [CNT_W-1:0]  blocked_cnt
);

    localparam int unsigned HRAM_AW = $clog2(HRAM_DEPTH);

    dma_owner_t          owner_q;
    dma_owner_t          owner_d;
    mem_req_t            mem_req;
    logic                cpu_hram;
    logic                cpu_blocked;
    logic                dma_stray;
    logic [HRAM_AW-1:0]  hram_idx;
    logic [DATA_W-1:0]   hram_rdata_c;
    logic [DATA_W-1:0]   blocked_rdata;

    assign cpu_hram    = in_hram(cpu_addr);
    assign cpu_blocked = (cpu_read_en | cpu_write_en) && (owner_q != OWN_CPU) && !cpu_hram;
    assign hram_idx    = HRAM_AW'(cpu_addr - HRAM_start);

    hram_ram #(
        .DEPTH (HRAM_DEPTH),
        .AW    (HRAM_AW)
    ) u_hram (
        .clk     (clk),
        .we      (cpu_write_en && cpu_hram),
        .addr    (hram_idx),
        .wdata   (cpu_wdata),
        .rdata_c (hram_rdata_c)
    );

    // Ownership state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_CPU;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Next owner and bus steering.
    always_comb begin
        owner_d   = owner_q;
        mem_req   = '0;
        cpu_rdata = OPEN_BUS;
        dma_rdata = OPEN_BUS;
        dma_stray = 1'b0;

        case (owner_q)
            OWN_CPU: begin
                if (dma_active) begin
                    owner_d = OWN_DMA;
                end
                mem_req.addr     = cpu_addr;
                mem_req.wdata    = cpu_wdata;
                mem_req.read_en  = cpu_read_en  && !cpu_hram;
                mem_req.write_en = cpu_write_en && !cpu_hram;
                cpu_rdata        = mem_rdata;
                dma_stray        = dma_read_en | dma_write_en;
            end
            OWN_DMA: begin
                if (!dma_active) begin
                    owner_d = OWN_RELEASE;
                end
                mem_req.addr     = dma_addr;
                mem_req.wdata    = dma_wdata;
                mem_req.read_en  = dma_read_en;
                mem_req.write_en = dma_write_en;
                dma_rdata        = mem_rdata;
                cpu_rdata        = blocked_rdata;
            end
            OWN_RELEASE: begin
                owner_d   = OWN_CPU;
                cpu_rdata = blocked_rdata;
                dma_stray = dma_read_en | dma_write_en;
            end
            default: begin
                owner_d = OWN_CPU;
            end
        endcase

        // HRAM is private to the CPU in every state.
        if (cpu_hram) begin
            cpu_rdata = hram_rdata_c;
        end
    end

    assign mem_addr     = mem_req.addr;
    assign mem_wdata    = mem_req.wdata;
    assign mem_read_en  = mem_req.read_en;
    assign mem_write_en = mem_req.write_en;
    assign owner        = owner_q;

    // Saturating count of CPU accesses refused while the DMA holds the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            blocked_cnt <= '0;
        end else if (cpu_blocked && (blocked_cnt != {CNT_W{1'b1}})) begin
            blocked_cnt <= blocked_cnt + CNT_W'(1);
        end
    end

`ifdef DMA_BUS_CONFLICT_EN
    logic [DATA_W-1:0] conflict_q;

    // Blocked reads see whatever the DMA last pulled off the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q <= OPEN_BUS;
        end else if ((owner_q == OWN_DMA) && dma_read_en) begin
            conflict_q <= mem_rdata;
        end
    end

    assign blocked_rdata = conflict_q;
`else
    assign blocked_rdata = OPEN_BUS;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && dma_stray) begin
            $warning("LOG_WARN dma_bus_arbiter: DMA strobe ignored, owner=%0d addr=%h", owner_q, dma_addr);
        end
    end
`endif

endmodule
